// File: rtl/renode_pkg.sv
// renode_pkg: shared types for the Renode bus scheduler and its round-robin arbiter.
package renode_pkg;

    // Default bus geometry used by the request struct below.
    localparam int unsigned BusAddressWidth = 32;
    localparam int unsigned BusDataWidth    = 32;

    typedef logic [BusAddressWidth-1:0] address_t;
    typedef logic [BusDataWidth-1:0]    data_t;

    // Scheduler FSM: one transaction in flight at a time.
    typedef enum logic [1:0] {
        SchedIdle,
        SchedIssue,
        SchedWait,
        SchedRespond
    } bus_sched_state_e;

    // One latched requester transaction at the default bus geometry.
    typedef struct packed {
        logic     write;
        address_t address;
        data_t    data;
    } bus_sched_request_t;

    // Width of an index able to address 'count' items, never narrower than one bit.
    function automatic int unsigned index_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/renode_rr_arbiter.sv
// renode_rr_arbiter: combinational round-robin pick of the first requester at or
// after the pointer, wrapping cyclically. The pointer register lives in the caller.
module renode_rr_arbiter
    import renode_pkg::*;
#(
    parameter  int unsigned Count      = 2,
    localparam int unsigned IndexWidth = index_width(Count)
) (
    input  logic [Count-1:0]      request,
    input  logic [IndexWidth-1:0] pointer,
    output logic [Count-1:0]      grant,
    output logic [IndexWidth-1:0] index,
    output logic                  grant_valid
);

    int unsigned slot;

    // Scan Count slots starting at the pointer; the first active request wins.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        grant       = '0;
        index       = '0;
        grant_valid = 1'b0;
        slot        = 0;
        for (int unsigned offset = 0; offset < Count; offset++) begin
            slot = 32'(pointer) + offset;
            if (slot >= Count) begin
                slot = slot - Count;
            end
            if (!grant_valid && request[slot[IndexWidth-1:0]]) begin
                grant_valid                     = 1'b1;
                grant[slot[IndexWidth-1:0]]     = 1'b1;
                index                           = slot[IndexWidth-1:0];
            end
        end
    end

endmodule

// File: rtl/renode_bus_scheduler.sv
// renode_bus_scheduler: shares one bus-controller port between RequestersCount
// requesters with round-robin grants, one transaction at a time.
// Optional feature macro RENODE_BUS_SCHEDULER_TIMEOUT_EN: bounds each bus
// transaction with a TimeoutCycles watchdog that drives bus_abort and rsp_timeout.
// Without it WAIT lasts until bus_done and both of those outputs are tied 0.
module renode_bus_scheduler
    import renode_pkg::*;
#(
    parameter int unsigned RequestersCount = 2,
    parameter int unsigned AddressWidth    = 32,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned TimeoutCycles   = 100
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [RequestersCount-1:0]                   req_valid,
    output logic [RequestersCount-1:0]                   req_ready,
    input  logic [RequestersCount-1:0]                   req_write,
    input  logic [RequestersCount-1:0][AddressWidth-1:0] req_address,
    input  logic [RequestersCount-1:0][DataWidth-1:0]    req_data,
    output logic [RequestersCount-1:0]                   rsp_valid,
    output logic [DataWidth-1:0]                         rsp_data,
    output logic                                         rsp_error,
    output logic                                         rsp_timeout,
    output logic                                         bus_valid,
    output logic                                         bus_write,
    output logic [AddressWidth-1:0]                      bus_address,
    output logic [DataWidth-1:0]                         bus_wdata,
    input  logic                                         bus_done,
    input  logic [DataWidth-1:0]                         bus_rdata,
    input  logic                                         bus_error,
    output logic                                         bus_abort
);

    localparam int unsigned IndexWidth = index_width(RequestersCount);

    // Parameter sanity, resolved at elaboration.
    if (RequestersCount < 1) begin : g_bad_requesters
        $error("renode_bus_scheduler: RequestersCount must be >= 1");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("renode_bus_scheduler: TimeoutCycles must be >= 1");
    end

    // Transaction latched at accept, sized to this instance's bus geometry.
    typedef struct packed {
        logic                    write;
        logic [AddressWidth-1:0] address;
        logic [DataWidth-1:0]    data;
    } request_t;

    bus_sched_state_e             state_q, state_d;
    logic [IndexWidth-1:0]        pointer_q, pointer_d;
    logic [IndexWidth-1:0]        owner_q, owner_d;
    request_t                     request_q, request_d;
    logic                         bus_valid_q, bus_valid_d;
    logic [RequestersCount-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0]         rsp_data_q, rsp_data_d;
    logic                         rsp_error_q, rsp_error_d;

`ifdef RENODE_BUS_SCHEDULER_TIMEOUT_EN
    localparam int unsigned CountWidth = index_width(TimeoutCycles);
    logic [CountWidth-1:0] count_q, count_d;
    logic                  bus_abort_q, bus_abort_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  expired;

    assign expired     = (count_q == CountWidth'(TimeoutCycles - 1));
    assign bus_abort   = bus_abort_q;
    assign rsp_timeout = rsp_timeout_q;
`else
    assign bus_abort   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    logic [RequestersCount-1:0] grant;
    logic [IndexWidth-1:0]      grant_index;
    logic                       grant_valid;

    renode_rr_arbiter #(
        .Count (RequestersCount)
    ) u_arbiter (
        .request     (req_valid),
        .pointer     (pointer_q),
        .grant       (grant),
        .index       (grant_index),
        .grant_valid (grant_valid)
    );

    // Offer the arbitration winner only while idle; the grant is already limited to valid requesters.
    assign req_ready   = (state_q == SchedIdle) ? grant : '0;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;
    assign bus_valid   = bus_valid_q;
    assign bus_write   = request_q.write;
    assign bus_address = request_q.address;
    assign bus_wdata   = request_q.data;

    // Next-state and next-output logic for the IDLE -> ISSUE -> WAIT -> RESPOND cycle.
    always_comb begin
        state_d     = state_q;
        pointer_d   = pointer_q;
        owner_d     = owner_q;
        request_d   = request_q;
        bus_valid_d = bus_valid_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
`ifdef RENODE_BUS_SCHEDULER_TIMEOUT_EN
        count_d       = count_q;
        bus_abort_d   = 1'b0;
        rsp_timeout_d = rsp_timeout_q;
`endif
        unique case (state_q)
            SchedIdle: begin
                if (grant_valid) begin
                    owner_d           = grant_index;
                    request_d.write   = req_write[grant_index];
                    request_d.address = req_address[grant_index];
                    request_d.data    = req_data[grant_index];
                    pointer_d         = (32'(grant_index) == RequestersCount - 1) ? '0
                                                                                  : grant_index + 1'b1;
                    bus_valid_d       = 1'b1;
                    state_d           = SchedIssue;
                end
            end
            SchedIssue: begin
`ifdef RENODE_BUS_SCHEDULER_TIMEOUT_EN
                count_d = '0;
`endif
                state_d = SchedWait;
            end
            SchedWait: begin
                if (bus_done) begin
                    // A completion in the expiry cycle still counts as a normal response.
                    bus_valid_d          = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_data_d           = (request_q.write || bus_error) ? '0 : bus_rdata;
                    rsp_error_d          = bus_error;
`ifdef RENODE_BUS_SCHEDULER_TIMEOUT_EN
                    rsp_timeout_d        = 1'b0;
`endif
                    state_d              = SchedRespond;
                end
`ifdef RENODE_BUS_SCHEDULER_TIMEOUT_EN
                else if (expired) begin
                    bus_valid_d          = 1'b0;
                    bus_abort_d          = 1'b1;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_data_d           = '0;
                    rsp_error_d          = 1'b1;
                    rsp_timeout_d        = 1'b1;
                    state_d              = SchedRespond;
                end else begin
                    count_d = count_q + 1'b1;
                end
`endif
            end
            SchedRespond: begin
                state_d = SchedIdle;
            end
            default: begin
                state_d = SchedIdle;
            end
        endcase
    end

    // State and registered outputs; reset drops any transaction in flight without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SchedIdle;
            pointer_q     <= '0;
            owner_q       <= '0;
            request_q     <= '0;
            bus_valid_q   <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
`ifdef RENODE_BUS_SCHEDULER_TIMEOUT_EN
            count_q       <= '0;
            bus_abort_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state_q       <= state_d;
            pointer_q     <= pointer_d;
            owner_q       <= owner_d;
            request_q     <= request_d;
            bus_valid_q   <= bus_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= rsp_error_d;
`ifdef RENODE_BUS_SCHEDULER_TIMEOUT_EN
            count_q       <= count_d;
            bus_abort_q   <= bus_abort_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

endmodule
